// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the pipeline and muldiv_unit
//
// Signals (master = pipeline, slave = muldiv_unit):
//   start     master->slave  request, sampled only while the unit is idle
//   FuncCode  master->slave  6-bit R-type function code
//   op_a      master->slave  rs operand (multiplicand / dividend / mthi-mtlo source)
//   op_b      master->slave  rt operand (multiplier / divisor)
//   abort     master->slave  cancel the in-flight operation
//   busy      slave->master  operation in progress
//   done      slave->master  one-cycle pulse when HI/LO are written
//   hi, lo    slave->master  architectural HI/LO registers
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       FuncCode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, FuncCode, op_a, op_b, abort,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, FuncCode, op_a, op_b, abort,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit holding MIPS HI/LO
//
// Executes mult, multu, div, divu, mthi, mtlo selected by the R-type function code.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave: start/FuncCode/op_a/op_b/abort in, busy/done/hi/lo out
// Optional feature: define MULDIV_FAST_MULT_EN for a single-cycle multiplier
// (IDLE -> MUL -> IDLE); otherwise multiplication is shift-add over WIDTH cycles.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] mag_a, mag_b;   // operand magnitudes
  logic [WIDTH-1:0] quo;            // div: dividend in / quotient out; mul: low product half
  logic [WIDTH:0]   rem;            // div: partial remainder; mul: high product half
  logic [CW-1:0]    cnt;
  logic             neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, busy_c;
`ifndef MULDIV_FAST_MULT_EN
  logic             op_mul;         // FIX must know which result format to write
  logic [WIDTH:0]   mul_sum;
`endif

  // Decode and operand conditioning
  logic             is_mul, is_div, is_signed, sign_a, sign_b, last;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [WIDTH+1:0] div_shift, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    is_mul    = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_MULTU);
    is_div    = (bus.FuncCode == F_DIV)  || (bus.FuncCode == F_DIVU);
    is_signed = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_DIV);
    sign_a    = is_signed & bus.op_a[WIDTH-1];
    sign_b    = is_signed & bus.op_b[WIDTH-1];
    cap_a     = sign_a ? -bus.op_a : bus.op_a;
    cap_b     = sign_b ? -bus.op_b : bus.op_b;
    last      = (cnt == '0);

    // Restoring step; the extra top bit of div_diff is the borrow/sign.
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {2'b00, mag_b};
    div_ge    = ~div_diff[WIDTH+1];

`ifdef MULDIV_FAST_MULT_EN
    prod      = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    mul_sum   = {1'b0, rem[WIDTH-1:0]} + (quo[0] ? {1'b0, mag_a} : '0);
    prod      = {rem[WIDTH-1:0], quo};
`endif
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = neg_res ? -quo : quo;
    // Remainder follows the dividend's sign (truncation toward zero).
    rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && is_mul)      state_nxt = S_MUL;
          else if (bus.start && is_div) state_nxt = S_DIV;
        end
`ifdef MULDIV_FAST_MULT_EN
        S_MUL:   state_nxt = S_IDLE;
`else
        S_MUL:   if (last) state_nxt = S_FIX;
`endif
        S_DIV:   if (last) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy_c = (state != S_IDLE);
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a    <= '0;
      mag_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifndef MULDIV_FAST_MULT_EN
      op_mul   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!bus.abort) begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.FuncCode == F_MTHI) begin
                hi_q   <= bus.op_a;
                done_q <= 1'b1;
              end else if (bus.FuncCode == F_MTLO) begin
                lo_q   <= bus.op_a;
                done_q <= 1'b1;
              end else if (is_mul || is_div) begin
                mag_a    <= cap_a;
                mag_b    <= cap_b;
                neg_res  <= sign_a ^ sign_b;
                neg_rem  <= sign_a;
                div_zero <= (bus.op_b == '0);
                cnt      <= CW'(WIDTH - 1);
                rem      <= '0;
                quo      <= is_mul ? cap_b : cap_a;
`ifndef MULDIV_FAST_MULT_EN
                op_mul   <= is_mul;
`endif
              end
            end
          end
          S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
            {hi_q, lo_q} <= prod_fix;
            done_q       <= 1'b1;
`else
            // Accumulator {rem, quo} shifts right; multiplier bits leave from quo[0].
            rem <= {1'b0, mul_sum[WIDTH:1]};
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
            cnt <= cnt - CW'(1);
`endif
          end
          S_DIV: begin
            rem <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], div_ge};
            cnt <= cnt - CW'(1);
          end
          S_FIX: begin
`ifndef MULDIV_FAST_MULT_EN
            if (op_mul) begin
              {hi_q, lo_q} <= prod_fix;
            end else
`endif
            begin
              // Divide by zero leaves quotient all ones; the remainder path
              // already reconstructs op_a since nothing was ever subtracted.
              hi_q <= rem_fix;
              lo_q <= div_zero ? '1 : quo_fix;
            end
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, {hi, lo}, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa  = $signed(a);
    sb  = $signed(b);
    res = '0;
    case (f)
      F_MULT:  res = sa * sb;
      F_MULTU: res = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else        res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Transaction-level model: result computed at acceptance, released after latency.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.abort) m_busy = 1'b0;
        else if (m_cnt == 1) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_busy = 1'b0;
        end else m_cnt--;
      end else if (bus.start && !bus.abort) begin
        case (bus.FuncCode)
          F_MTHI: begin m_hi = bus.op_a; m_done = 1'b1; end
          F_MTLO: begin m_lo = bus.op_a; m_done = 1'b1; end
          F_MULT, F_MULTU: begin
            {p_hi, p_lo} = ref_result(bus.FuncCode, bus.op_a, bus.op_b);
            m_busy = 1'b1; m_cnt = MUL_LAT;
          end
          F_DIV, F_DIVU: begin
            {p_hi, p_lo} = ref_result(bus.FuncCode, bus.op_a, bus.op_b);
            m_busy = 1'b1; m_cnt = DIV_LAT;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
    chk("cyc_done", 64'(bus.done), 64'(m_done));
    chk("cyc_hi",   64'(bus.hi),   64'(m_hi));
    chk("cyc_lo",   64'(bus.lo),   64'(m_lo));
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.FuncCode = f; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      cyc++;
      if (cyc > 100) begin
        chk({name, "_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int c;
    issue(f, a, b);
    wait_done(name, c);
    chk({name, "_lat"}, 64'(c), 64'(elat));
    chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({name, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int c, nd;
    bus.start = 1'b0; bus.abort = 1'b0; bus.FuncCode = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("mult",  F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT);
    run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);

    // Second start at E5 while busy must not disturb result or timing.
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (4) @(posedge clk);
    #1 begin bus.FuncCode = F_MTHI; bus.op_a = 32'hDEADBEEF; bus.start = 1'b1; end
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("div_busy", c);
    chk("div_busy_lat", 64'(c), 64'(DIV_LAT - 5));
    chk("div_busy_hi", 64'(bus.hi), 64'hFFFFFFFF);
    chk("div_busy_lo", 64'(bus.lo), 64'hFFFFFFFD);

    run_op("divu0",  F_DIVU, 32'h1234,     32'd0,        32'h00001234, 32'hFFFFFFFF, DIV_LAT);
    run_op("divmin", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
    run_op("divu",   F_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT);
    run_op("div_nb", F_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT);
    run_op("div0s",  F_DIV,  32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, DIV_LAT);
    run_op("multmn", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT);
    run_op("multu2", F_MULTU,32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT);
    run_op("mult_n", F_MULT, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MUL_LAT);

    run_op("mthi", F_MTHI, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, 32'hFFFFFFF9, 0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    run_op("mtlo", F_MTLO, 32'h5A5A5A5A, 32'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);

    // Undecoded function code is ignored.
    issue(F_ADD, 32'd1, 32'd2);
    count_done(5, nd);
    chk("inval_done", 64'(nd), 64'd0);
    chk("inval_busy", 64'(bus.busy), 64'd0);

    // Start coinciding with abort is ignored.
    bus.abort = 1'b1;
    issue(F_MULT, 32'd3, 32'd3);
    bus.abort = 1'b0;
    count_done(5, nd);
    chk("stab_done", 64'(nd), 64'd0);
    chk("stab_busy", 64'(bus.busy), 64'd0);

    // Abort at E10 of a divide.
    issue(F_DIV, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    count_done(40, nd);
    chk("abort_done", 64'(nd), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'hA5A5A5A5);
    chk("abort_lo", 64'(bus.lo), 64'h5A5A5A5A);

    // Reset at E20 of a divide.
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_hi", 64'(bus.hi), 64'd0);
    chk("mrst_lo", 64'(bus.lo), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_done(40, nd);
    chk("mrst_nodone", 64'(nd), 64'd0);

    run_op("post_rst", F_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_LAT);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative multiply/divide unit for the MIPS datapath.
- Executes mult, multu, div, divu, mthi and mtlo, keyed on the same 6-bit R-type function code the ALU control decodes.
- Holds the architectural HI/LO registers.
- Sits beside the combinational ALU. The pipeline stalls on `busy` and reads `hi`/`lo` for mfhi/mflo.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits. Must be even and ≥ 4.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request, sampled only in IDLE.
- `FuncCode` input 6: operation select, sampled with `start`.
- `op_a` input WIDTH: rs operand (multiplicand / dividend / mthi-mtlo source).
- `op_b` input WIDTH: rt operand (multiplier / divisor).
- `abort` input 1: cancel the in-flight operation; HI/LO are not written.
- `busy` output 1: operation in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse on the cycle HI/LO are updated.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **FuncCode decode:** 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo. Any other code with `start` is ignored: no state change, no `done`.
- **States:** IDLE, MUL, DIV, FIX.
  - IDLE to MUL / DIV on a valid mult*/div* start.
  - MUL / DIV to FIX after WIDTH iterations.
  - FIX to IDLE unconditionally.
  - Any state to IDLE on `abort`.
- **Start capture:**
  - Latch the magnitudes of the operands. Signed ops take the absolute value; unsigned ops pass through.
  - Latch the sign flags.
  - Load the iteration counter with WIDTH-1.
- **MUL:** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **DIV:** restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits so that |MIN| is handled.
- **FIX:**
  - Negate the product if the operand signs differ (signed mult).
  - For signed div, negate the quotient if the signs differ; the remainder takes the dividend's sign (truncate toward zero).
  - Write {hi,lo} = product, or lo = quotient, hi = remainder.
  - Pulse `done`.
- **Divide by zero (div/divu):** lo = all ones, hi = op_a unchanged. Full latency still applies.
- **MIN / -1 (signed div):** lo = MIN, hi = 0.
- **mthi / mtlo:** write hi or lo from op_a on the start edge. `done` pulses on the next cycle. `busy` never asserts.
- **abort:** takes priority over iteration and over FIX. HI/LO keep their prior values and `done` stays low. `start` in the same cycle as `abort` is ignored.

## Timing
- **Reset:** while `rst_n` = 0, all outputs clear asynchronously: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE.
- **Iterative latency:** `start` sampled at edge E0. `busy` is high from after E0 until after E(WIDTH+1). HI/LO update and `done` = 1 after E(WIDTH+1), i.e. 33 cycles at WIDTH = 32.
- **Back-to-back:** `done` and `busy` = 0 coincide. A new `start` is accepted in that same cycle.
- **mthi/mtlo:** updates after E0; `done` high after E0 for one cycle.
- **Reset mid-operation:** the operation is discarded and no `done` is produced after release.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - mult/multu use a single-cycle WIDTH×WIDTH multiplier (signed or unsigned).
  - FSM goes IDLE → MUL → IDLE.
  - HI/LO and `done` update after E1; `busy` is high for one cycle.
  - Division is unchanged.
- Undefined: iterative multiply as above, with no multiplier inferred.

## Test plan
- **Signed mult:** WIDTH = 32, mult op_a = 0xFFFFFFFD (-3), op_b = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. `done` after E33, or after E1 with MULDIV_FAST_MULT_EN.
- **Unsigned mult:** multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **Signed div, then start while busy:** div -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. A second `start` issued at E5 has no effect on the result or the timing.
- **Divide edge cases:**
  - divu 0x1234 / 0 → lo = 0xFFFFFFFF, hi = 0x1234 after E33.
  - div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **mthi, then abort:** mthi 0xA5A5A5A5 → hi = 0xA5A5A5A5 after E0, `busy` stays 0. Then start a div and assert `abort` at E10 → state IDLE, hi/lo unchanged, no `done`.
- **Reset mid-divide:** `rst_n` low at E20 of a divide → hi = lo = 0 and busy = done = 0 immediately. No `done` after release.
